ifu_fetch: RTL
==============

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the address of the first fetch after reset.
REQ-002 SHALL have parameter BUF_DEPTH, fixed at 2, meaning the number of instruction-buffer entries.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port imem_req_valid_o  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready_i  input  1  memory accepts the request; a request is accepted when valid and ready are both high in the same cycle.
REQ-007 SHALL have port imem_req_addr_o  output  `PC_WIDTH  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid_i  input  1  response valid; responses are in order, at least 1 cycle after acceptance, and cannot be back-pressured.
REQ-009 SHALL have port imem_rsp_data_i  input  `INSTR_WIDTH  fetched instruction.
REQ-010 SHALL have port redirect_i  input  1  flush and restart fetch (branch, jump or exception).
REQ-011 SHALL have port redirect_pc_i  input  `PC_WIDTH  new fetch PC.
REQ-012 SHALL have port if_valid_o  output  1  instruction available to decode.
REQ-013 SHALL have port if_ready_i  input  1  decode consumes the instruction when both if_valid_o and if_ready_i are high.
REQ-014 SHALL have port if_instr_o  output  `INSTR_WIDTH  instruction at the buffer head.
REQ-015 SHALL have port if_pc_o  output  `PC_WIDTH  PC of if_instr_o.

Function
REQ-016 SHALL implement FSM states FETCH and FLUSH; reset state is FETCH.
REQ-017 SHALL drive imem_req_valid_o = (state==FETCH) && !redirect_i && (outstanding + buf_count < 2).
REQ-018 SHALL drive imem_req_addr_o from the fetch-PC register and advance that register by 4 on each accepted request; wrap-around is modulo 2^`PC_WIDTH.
REQ-019 SHALL track outstanding requests (0..2): +1 on acceptance, -1 on response, unchanged when both occur in the same cycle.
REQ-020 SHALL, in FETCH, push {rsp_pc, imem_rsp_data_i} into the buffer on imem_rsp_valid_i and then advance rsp_pc by 4.
REQ-021 SHALL present the buffer head on if_instr_o/if_pc_o, with if_valid_o = (buf_count != 0) && (state==FETCH).
REQ-022 SHALL handle push and pop in the same cycle with buf_count unchanged and order preserved.
REQ-023 SHALL never overflow the buffer; the credit rule of REQ-017 guarantees this, and an assertion checks it.
REQ-024 SHALL, on redirect_i: empty the buffer; load fetch PC and rsp_pc with {redirect_pc_i[PC_WIDTH-1:2],2'b00}; go to FLUSH if outstanding (after this cycle's updates) is non-zero, otherwise go to FETCH.
REQ-025 SHALL, in FLUSH, discard every response, decrement outstanding, and return to FETCH in the cycle after outstanding reaches 0.
REQ-026 SHALL treat a redirect in FLUSH by reloading the PCs and remaining in FLUSH.
REQ-027 SHALL give a redirect priority over a pop in the same cycle; the popped instruction is still considered consumed by decode.
REQ-028 SHALL have a minimum latency of 1 cycle from response to if_valid_o.

Reset
REQ-029 SHALL, while rst_n is low, set: fetch PC = rsp_pc = RESET_PC; outstanding = 0; buf_count = 0; state = FETCH.
REQ-030 SHALL therefore hold imem_req_valid_o = 0 and if_valid_o = 0 during reset, and if_instr_o = if_pc_o = 0.
REQ-031 SHALL ignore responses to requests issued before a mid-operation reset.

Structure
REQ-032 SHALL take `PC_WIDTH, `INSTR_WIDTH, RESET_PC default and FSM state encodings from the shared defines.v.
REQ-033 SHALL place the buffer in sub-module ifu_fetch_buf: 2-entry synchronous FIFO, with flush input, count output and same-cycle push/pop.

Verification
REQ-034 SHALL cover this scenario: reset with RESET_PC=0, memory ready always, 1-cycle response, decode always ready -> addresses 0,4,8,... issued; decode sees a steady stream with pc matching address.
REQ-035 SHALL cover this scenario: if_ready_i=0 for 10 cycles -> exactly 2 requests issued (0,4), then imem_req_valid_o=0; on release, pc 0 then 4 delivered, then fetch resumes at 8.
REQ-036 SHALL cover this scenario: redirect_pc_i=32'h100 with 2 outstanding and 3-cycle memory latency -> both responses dropped, FLUSH held until outstanding=0, next request address 32'h100, first delivered pc 32'h100.
REQ-037 SHALL cover this scenario: redirect_pc_i=32'h203 -> next fetch address 32'h200.
REQ-038 SHALL cover this scenario: fetch PC 32'hFFFF_FFFC -> next address 32'h0000_0000.
REQ-039 SHALL cover this scenario: rst_n pulsed low mid-stream with 1 outstanding -> outputs clear at once; late response ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_pkg
// Purpose  : Shared widths, reset PC default, FSM state encoding and helpers
//            for the instruction-fetch unit and its instruction buffer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ifu_fetch_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;
  // One buffer entry holds {pc, instruction}.
  localparam int ENTRY_W     = PC_WIDTH + INSTR_WIDTH;

  localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK       = {{(PC_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [PC_WIDTH-1:0] PC_STEP          = PC_WIDTH'(4);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  // Force a PC onto a word boundary.
  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return pc & ALIGN_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_buf
// Purpose  : Two-entry synchronous FIFO holding fetched {pc, instr} pairs.
//            Supports push and pop in the same cycle and a flush that empties
//            the buffer (flush wins over push/pop).
// Ports    : clk, rst_n      - clock, async active-low reset
//            i_flush         - discard all entries
//            i_push/i_entry  - write one entry at the tail
//            i_pop           - drop the head entry
//            o_head          - entry at the head
//            o_count         - number of valid entries (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_buf
  import ifu_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_entry,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic [1:0]         o_count
);

  logic [ENTRY_W-1:0] r_mem [0:1];
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic [1:0]         r_count;
  logic               w_do_pop;

  // A pop of an empty buffer is meaningless; ignore it defensively.
  assign w_do_pop = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Instruction-fetch unit. Issues word-aligned fetch requests under
//            a two-credit flow control, buffers in-order responses in a
//            two-entry buffer and presents them to decode. A redirect empties
//            the buffer, restarts fetch at the new PC and drains (drops) any
//            responses still in flight via the FLUSH state.
// Ports    : clk, rst_n                      - clock, async active-low reset
//            imem_req_valid_o/ready_i/addr_o - fetch request channel
//            imem_rsp_valid_i/data_i         - in-order response channel
//            redirect_i, redirect_pc_i       - flush and restart fetch
//            if_valid_o/ready_i              - decode handshake
//            if_instr_o, if_pc_o             - buffer head and its PC
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int                  BUF_DEPTH = 2
)(
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid_o,
  input  logic                   imem_req_ready_i,
  output logic [PC_WIDTH-1:0]    imem_req_addr_o,
  input  logic                   imem_rsp_valid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
  input  logic                   redirect_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  output logic                   if_valid_o,
  input  logic                   if_ready_i,
  output logic [INSTR_WIDTH-1:0] if_instr_o,
  output logic [PC_WIDTH-1:0]    if_pc_o
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [PC_WIDTH-1:0] r_rsp_pc;
  logic [PC_WIDTH-1:0] w_redirect_pc;
  logic [1:0]          r_outstanding;
  logic [1:0]          w_outstanding_nxt;
  logic [1:0]          w_buf_count;
  logic [ENTRY_W-1:0]  w_head;
  logic                w_credit_ok;
  logic                w_req_fire;
  logic                w_rsp_fire;
  logic                w_push;
  logic                w_pop;

  assign w_redirect_pc = align_pc(redirect_pc_i);

  // Requests in flight plus buffered entries may never exceed the buffer
  // depth, so every response is guaranteed a free slot.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_buf_count}) < 3'(BUF_DEPTH);

  // rst_n gates the request so it drops immediately on async reset assertion,
  // not only after the registers settle to an idle state.
  assign imem_req_valid_o = rst_n && (r_state == FETCH) && !redirect_i && w_credit_ok;
  assign imem_req_addr_o  = r_fetch_pc;
  assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;

  // With nothing outstanding a response can only belong to a request issued
  // before a reset, so it is ignored.
  assign w_rsp_fire = imem_rsp_valid_i && (r_outstanding != 2'd0);
  assign w_push     = w_rsp_fire && (r_state == FETCH) && !redirect_i;

  assign if_valid_o = (w_buf_count != 2'd0) && (r_state == FETCH);
  assign w_pop      = if_valid_o && if_ready_i;
  assign if_pc_o    = w_head[ENTRY_W-1 -: PC_WIDTH];
  assign if_instr_o = w_head[INSTR_WIDTH-1:0];

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    case ({w_req_fire, w_rsp_fire})
      2'b10:   w_outstanding_nxt = r_outstanding + 2'd1;
      2'b01:   w_outstanding_nxt = r_outstanding - 2'd1;
      default: w_outstanding_nxt = r_outstanding;
    endcase
  end

  // A redirect, or any cycle spent flushing, lands in FLUSH while responses
  // remain in flight and in FETCH once the last one has been dropped.
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_i || (r_state == FLUSH)) begin
      w_state_nxt = (w_outstanding_nxt != 2'd0) ? FLUSH : FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= 2'd0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (redirect_i) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + PC_STEP;
        end
      end
    end
  end

  ifu_fetch_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_i),
    .i_push  (w_push),
    .i_entry ({r_rsp_pc, imem_rsp_data_i}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_buf_count)
  );

  a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && !redirect_i && (w_buf_count == 2'(BUF_DEPTH))));

endmodule
`default_nettype wire
